hynoc_local_interface: RTL and testbench

HYNOC_LOCAL_INTERFACE -- requirements
Module: hynoc_local_interface

---
 rtl/hynoc_local_interface_pkg.sv | 8 +
 rtl/hynoc_local_fifo.sv | 64 ++++++
 rtl/hynoc_local_interface.sv | 81 ++++++++
 tb/tb_hynoc_local_interface.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hynoc_local_interface_pkg.sv
// Shared defaults for the HyNoC local interface: flit width, FIFO depth and level width.
package hynoc_local_interface_pkg;

    localparam int FLIT_WIDTH_DEF      = 33;
    localparam int LOG2_FIFO_DEPTH_DEF = 5;
    localparam int LEVEL_W_DEF         = LOG2_FIFO_DEPTH_DEF + 1;

endpackage

// File: rtl/hynoc_local_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy level, full and empty.
module hynoc_local_fifo
    import hynoc_local_interface_pkg::*;
#(
    parameter int LOG2_DEPTH = LOG2_FIFO_DEPTH_DEF,
    parameter int WIDTH      = FLIT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic [LOG2_DEPTH:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam int LW    = LOG2_DEPTH + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [LW-1:0]         level_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Storage is never reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign level    = level_q;

endmodule

// File: rtl/hynoc_local_interface.sv
// Local endpoint adapter for a HyNoC router: ingress and egress FWFT FIFOs in one clock domain.
module hynoc_local_interface
    import hynoc_local_interface_pkg::*;
#(
    parameter int LOG2_FIFO_DEPTH = LOG2_FIFO_DEPTH_DEF,
    parameter int FLIT_WIDTH      = FLIT_WIDTH_DEF,
    parameter int SINGLE_CLOCK    = 1
) (
    input  logic                       local_clk,
    input  logic                       local_srst,
    input  logic                       port_egress_clk,
    input  logic                       port_egress_srst,
    output logic                       port_ingress_clk,
    output logic                       port_ingress_srst,
    output logic                       port_ingress_write,
    output logic [FLIT_WIDTH-1:0]      port_ingress_data,
    input  logic                       port_ingress_full,
    input  logic [LOG2_FIFO_DEPTH:0]   port_ingress_fifo_level,
    input  logic                       port_egress_write,
    input  logic [FLIT_WIDTH-1:0]      port_egress_data,
    output logic [LOG2_FIFO_DEPTH:0]   port_egress_fifo_level,
    input  logic                       local_ingress_write,
    input  logic [FLIT_WIDTH-1:0]      local_ingress_data,
    output logic                       local_ingress_full,
    output logic [LOG2_FIFO_DEPTH:0]   local_ingress_fifo_level,
    input  logic                       local_egress_read,
    output logic [FLIT_WIDTH-1:0]      local_egress_data,
    output logic                       local_egress_empty,
    output logic [LOG2_FIFO_DEPTH:0]   local_egress_fifo_level
);

    logic                     srst;
    logic                     ing_empty;
    logic                     eg_full;
    logic [LOG2_FIFO_DEPTH:0] eg_level;
    logic                     unused_inputs;

    assign srst              = local_srst | port_egress_srst;
    assign port_ingress_clk  = local_clk;
    assign port_ingress_srst = local_srst;

    // Router side pops the ingress head on every cycle it is offered and accepted.
    assign port_ingress_write = ~ing_empty & ~port_ingress_full;

    hynoc_local_fifo #(
        .LOG2_DEPTH (LOG2_FIFO_DEPTH),
        .WIDTH      (FLIT_WIDTH)
    ) u_ingress_fifo (
        .clk       (local_clk),
        .srst      (srst),
        .push      (local_ingress_write),
        .push_data (local_ingress_data),
        .pop       (port_ingress_write),
        .pop_data  (port_ingress_data),
        .level     (local_ingress_fifo_level),
        .full      (local_ingress_full),
        .empty     (ing_empty)
    );

    hynoc_local_fifo #(
        .LOG2_DEPTH (LOG2_FIFO_DEPTH),
        .WIDTH      (FLIT_WIDTH)
    ) u_egress_fifo (
        .clk       (local_clk),
        .srst      (srst),
        .push      (port_egress_write),
        .push_data (port_egress_data),
        .pop       (local_egress_read),
        .pop_data  (local_egress_data),
        .level     (eg_level),
        .full      (eg_full),
        .empty     (local_egress_empty)
    );

    assign port_egress_fifo_level  = eg_level;
    assign local_egress_fifo_level = eg_level;

    // Router clock is the same net as local_clk; router level and egress full are informational.
    assign unused_inputs = &{1'b0, port_egress_clk, port_ingress_fifo_level, eg_full, SINGLE_CLOCK[0]};

endmodule

// File: tb/tb_hynoc_local_interface.sv
// Directed bench for hynoc_local_interface: queue-based FIFO model checked every cycle plus literal pins.
module tb_hynoc_local_interface;
    import hynoc_local_interface_pkg::*;

    localparam int FW = FLIT_WIDTH_DEF;
    localparam int LG = LOG2_FIFO_DEPTH_DEF;
    localparam int LW = LEVEL_W_DEF;
    localparam int D  = 1 << LG;

    logic          clk;
    logic          local_srst;
    logic          port_egress_clk;
    logic          port_egress_srst;
    logic          port_ingress_clk;
    logic          port_ingress_srst;
    logic          port_ingress_write;
    logic [FW-1:0] port_ingress_data;
    logic          port_ingress_full;
    logic [LW-1:0] port_ingress_fifo_level;
    logic          port_egress_write;
    logic [FW-1:0] port_egress_data;
    logic [LW-1:0] port_egress_fifo_level;
    logic          local_ingress_write;
    logic [FW-1:0] local_ingress_data;
    logic          local_ingress_full;
    logic [LW-1:0] local_ingress_fifo_level;
    logic          local_egress_read;
    logic [FW-1:0] local_egress_data;
    logic          local_egress_empty;
    logic [LW-1:0] local_egress_fifo_level;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign port_egress_clk = clk;

    hynoc_local_interface #(
        .LOG2_FIFO_DEPTH (LG),
        .FLIT_WIDTH      (FW),
        .SINGLE_CLOCK    (1)
    ) dut (
        .local_clk                (clk),
        .local_srst               (local_srst),
        .port_egress_clk          (port_egress_clk),
        .port_egress_srst         (port_egress_srst),
        .port_ingress_clk         (port_ingress_clk),
        .port_ingress_srst        (port_ingress_srst),
        .port_ingress_write       (port_ingress_write),
        .port_ingress_data        (port_ingress_data),
        .port_ingress_full        (port_ingress_full),
        .port_ingress_fifo_level  (port_ingress_fifo_level),
        .port_egress_write        (port_egress_write),
        .port_egress_data         (port_egress_data),
        .port_egress_fifo_level   (port_egress_fifo_level),
        .local_ingress_write      (local_ingress_write),
        .local_ingress_data       (local_ingress_data),
        .local_ingress_full       (local_ingress_full),
        .local_ingress_fifo_level (local_ingress_fifo_level),
        .local_egress_read        (local_egress_read),
        .local_egress_data        (local_egress_data),
        .local_egress_empty       (local_egress_empty),
        .local_egress_fifo_level  (local_egress_fifo_level)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] pat(input int i);
        logic [31:0] lo;
        lo = 32'hC0DE_0000 + 32'(i);
        return FW'({~i[0], lo});
    endfunction

    // Model: two bounded queues; pushes beyond D are dropped, pops on empty ignored.
    logic [FW-1:0] q_ing[$];
    logic [FW-1:0] q_eg[$];
    bit            model_ok = 1'b0;

    always @(posedge clk) begin
        int n;
        if (local_srst || port_egress_srst) begin
            q_ing.delete();
            q_eg.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            n = q_ing.size();
            if (n != 0 && !port_ingress_full) void'(q_ing.pop_front());
            if (local_ingress_write && n < D) q_ing.push_back(local_ingress_data);
            n = q_eg.size();
            if (n != 0 && local_egress_read) void'(q_eg.pop_front());
            if (port_egress_write && n < D) q_eg.push_back(port_egress_data);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("ing_level", 64'(local_ingress_fifo_level), 64'(q_ing.size()));
            chk("ing_full", 64'(local_ingress_full), 64'(q_ing.size() == D));
            chk("pi_write", 64'(port_ingress_write), 64'(q_ing.size() != 0 && !port_ingress_full));
            if (q_ing.size() != 0) chk("pi_data", 64'(port_ingress_data), 64'(q_ing[0]));
            chk("eg_level", 64'(local_egress_fifo_level), 64'(q_eg.size()));
            chk("pe_level", 64'(port_egress_fifo_level), 64'(q_eg.size()));
            chk("eg_empty", 64'(local_egress_empty), 64'(q_eg.size() == 0));
            if (q_eg.size() != 0) chk("eg_data", 64'(local_egress_data), 64'(q_eg[0]));
            chk("pi_srst", 64'(port_ingress_srst), 64'(local_srst));
            chk("pi_clk", 64'(port_ingress_clk), 64'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] sent[$];
        int            k;
        int            rcount;

        local_srst              = 1'b1;
        port_egress_srst        = 1'b0;
        port_ingress_full       = 1'b0;
        port_ingress_fifo_level = '0;
        port_egress_write       = 1'b0;
        port_egress_data        = '0;
        local_ingress_write     = 1'b0;
        local_ingress_data      = '0;
        local_egress_read       = 1'b0;

        // Reset for three cycles
        repeat (3) step();
        local_srst = 1'b0;
        @(negedge clk);
        chk("rst_ing_level", 64'(local_ingress_fifo_level), 64'd0);
        chk("rst_eg_level", 64'(local_egress_fifo_level), 64'd0);
        chk("rst_eg_empty", 64'(local_egress_empty), 64'd1);
        chk("rst_pi_write", 64'(port_ingress_write), 64'd0);
        step();

        // Single flit passes local ingress to router in one cycle
        local_ingress_write = 1'b1;
        local_ingress_data  = 33'h1_0000_00AA;
        step();
        local_ingress_write = 1'b0;
        @(negedge clk);
        chk("single_write", 64'(port_ingress_write), 64'd1);
        chk("single_data", 64'(port_ingress_data), 64'h1_0000_00AA);
        step();
        @(negedge clk);
        chk("single_level0", 64'(local_ingress_fifo_level), 64'd0);
        step();

        // Backpressure: 33 pushes, 32 kept, released in order
        port_ingress_full = 1'b1;
        for (int i = 0; i < 33; i++) begin
            local_ingress_write = 1'b1;
            local_ingress_data  = pat(i);
            step();
        end
        local_ingress_write = 1'b0;
        @(negedge clk);
        chk("bp_level32", 64'(local_ingress_fifo_level), 64'd32);
        chk("bp_full", 64'(local_ingress_full), 64'd1);
        chk("bp_no_write", 64'(port_ingress_write), 64'd0);
        step();
        port_ingress_full = 1'b0;
        k = 0;
        for (int c = 0; c < 40 && k < 32; c++) begin
            @(negedge clk);
            if (port_ingress_write) begin
                chk("bp_order", 64'(port_ingress_data), 64'(pat(k)));
                k++;
            end
        end
        chk("bp_count", 64'(k), 64'd32);
        step();
        @(negedge clk);
        chk("bp_drained", 64'(local_ingress_fifo_level), 64'd0);
        step();

        // Router fills egress: 33 writes, 32 kept, drained 0..31
        for (int i = 0; i < 33; i++) begin
            port_egress_write = 1'b1;
            port_egress_data  = FW'(i);
            step();
        end
        port_egress_write = 1'b0;
        @(negedge clk);
        chk("eg_level32", 64'(port_egress_fifo_level), 64'd32);
        chk("eg_msb", 64'(port_egress_fifo_level[LW-1]), 64'd1);
        step();
        local_egress_read = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("eg_drain", 64'(local_egress_data), 64'(i));
            step();
        end
        local_egress_read = 1'b0;
        @(negedge clk);
        chk("eg_empty_after", 64'(local_egress_empty), 64'd1);
        step();

        // Random 25% router writes, local reads whenever non-empty
        rcount = 0;
        for (int c = 0; c < 110; c++) begin
            port_egress_write = (c < 100) && ($urandom_range(3) == 0);
            port_egress_data  = FW'({$urandom(), $urandom()});
            if (port_egress_write) sent.push_back(port_egress_data);
            local_egress_read = (local_egress_fifo_level != '0);
            if (local_egress_read) begin
                if (rcount < sent.size()) chk("stream_data", 64'(local_egress_data), 64'(sent[rcount]));
                else chk("stream_extra", 64'(rcount), 64'(sent.size()));
                rcount++;
            end
            step();
        end
        port_egress_write = 1'b0;
        local_egress_read = 1'b0;
        chk("stream_count", 64'(rcount), 64'(sent.size()));
        @(negedge clk);
        step();

        // Simultaneous push and pop at level 5, then reset at level 10
        port_ingress_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            local_ingress_write = 1'b1;
            local_ingress_data  = pat(100 + i);
            step();
        end
        local_ingress_write = 1'b0;
        @(negedge clk);
        chk("lvl5", 64'(local_ingress_fifo_level), 64'd5);
        step();
        local_ingress_write = 1'b1;
        local_ingress_data  = pat(105);
        port_ingress_full   = 1'b0;
        step();
        local_ingress_write = 1'b0;
        port_ingress_full   = 1'b1;
        @(negedge clk);
        chk("lvl5_pushpop", 64'(local_ingress_fifo_level), 64'd5);
        chk("pushpop_head", 64'(port_ingress_data), 64'(pat(101)));
        step();
        for (int i = 0; i < 5; i++) begin
            local_ingress_write = 1'b1;
            local_ingress_data  = pat(106 + i);
            step();
        end
        local_ingress_write = 1'b0;
        @(negedge clk);
        chk("lvl10", 64'(local_ingress_fifo_level), 64'd10);
        step();
        local_srst = 1'b1;
        step();
        local_srst = 1'b0;
        @(negedge clk);
        chk("rst10_level", 64'(local_ingress_fifo_level), 64'd0);
        chk("rst10_full", 64'(local_ingress_full), 64'd0);
        chk("rst10_write", 64'(port_ingress_write), 64'd0);
        step();

        // Router-side reset also clears the egress FIFO
        port_ingress_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            port_egress_write = 1'b1;
            port_egress_data  = pat(200 + i);
            step();
        end
        port_egress_write = 1'b0;
        @(negedge clk);
        chk("eg_lvl3", 64'(local_egress_fifo_level), 64'd3);
        step();
        port_egress_srst = 1'b1;
        step();
        port_egress_srst = 1'b0;
        @(negedge clk);
        chk("prst_eg_level", 64'(local_egress_fifo_level), 64'd0);
        chk("prst_eg_empty", 64'(local_egress_empty), 64'd1);
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
